// File: rtl/div_16.sv
// 16-bit unsigned restoring divider, one quotient bit per clock.
// Returns quotient/remainder with a single-cycle done pulse.
module div_16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [15:0] divisor,
  output logic [15:0] quotient,
  output logic [15:0] remainder,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_state_nx;
  logic [3:0]  r_count;
  logic [3:0]  w_count_nx;
  logic [15:0] r_q;
  logic [15:0] w_q_nx;
  logic [15:0] r_r;
  logic [15:0] w_r_nx;
  logic [15:0] r_dvsr;
  logic [15:0] w_dvsr_nx;
  logic [15:0] r_quot;
  logic [15:0] w_quot_nx;
  logic [15:0] r_rem;
  logic [15:0] w_rem_nx;
  logic        r_dbz;
  logic        w_dbz_nx;
  logic [16:0] w_shift;
  logic [16:0] w_trial;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_count <= 4'd0;
      r_q     <= 16'd0;
      r_r     <= 16'd0;
      r_dvsr  <= 16'd0;
      r_quot  <= 16'd0;
      r_rem   <= 16'd0;
      r_dbz   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_count <= w_count_nx;
      r_q     <= w_q_nx;
      r_r     <= w_r_nx;
      r_dvsr  <= w_dvsr_nx;
      r_quot  <= w_quot_nx;
      r_rem   <= w_rem_nx;
      r_dbz   <= w_dbz_nx;
    end
  end

  // Trial subtract as add of the inverted divisor; bit 16 is the borrow.
  assign w_shift = {r_r, r_q[15]};
  assign w_trial = w_shift + {1'b1, ~r_dvsr} + 17'd1;

  always_comb begin
    w_state_nx = r_state;
    w_count_nx = r_count;
    w_q_nx     = r_q;
    w_r_nx     = r_r;
    w_dvsr_nx  = r_dvsr;
    w_quot_nx  = r_quot;
    w_rem_nx   = r_rem;
    w_dbz_nx   = r_dbz;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          if (divisor != 16'd0) begin
            w_dvsr_nx  = divisor;
            w_q_nx     = dividend;
            w_r_nx     = 16'd0;
            w_count_nx = 4'd0;
            w_state_nx = S_RUN;
          end else begin
            w_quot_nx  = 16'hFFFF;
            w_rem_nx   = dividend;
            w_dbz_nx   = 1'b1;
            w_state_nx = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (!w_trial[16]) begin
          w_r_nx = w_trial[15:0];
          w_q_nx = {r_q[14:0], 1'b1};
        end else begin
          w_r_nx = w_shift[15:0];
          w_q_nx = {r_q[14:0], 1'b0};
        end
        w_count_nx = r_count + 4'd1;
        if (r_count == 4'd15) begin
          w_quot_nx  = w_q_nx;
          w_rem_nx   = w_r_nx;
          w_dbz_nx   = 1'b0;
          w_state_nx = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nx = S_IDLE;
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz;
  assign busy        = (r_state == S_RUN);
  assign done        = (r_state == S_DONE);

endmodule

// File: tb/tb_div_16.sv
// Bench for div_16: directed cases plus random operands
// against a plain a/b, a%b reference.
module tb_div_16;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int n_checks;
  int n_errors;

  div_16 dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .remainder  (remainder),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic run_op(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] eq;
    logic [15:0] er;
    logic        edz;
    int          exp_lat;
    int          cyc;
    int          bad_busy;
    edz     = (b == 16'd0);
    eq      = edz ? 16'hFFFF : a / b;
    er      = edz ? a : a % b;
    exp_lat = edz ? 0 : 16;
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0;
    dividend = 16'($urandom);
    divisor = 16'($urandom);
    cyc = 0;
    bad_busy = 0;
    while (done !== 1'b1 && cyc < 40) begin
      if (busy !== !edz) bad_busy++;
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (cyc !== exp_lat) begin
      n_errors++;
      $display("FAIL latency %0d/%0d got %0d exp %0d", a, b, cyc, exp_lat);
    end
    n_checks++;
    if (bad_busy !== 0) begin
      n_errors++;
      $display("FAIL busy_run %0d/%0d bad cycles %0d exp 0", a, b, bad_busy);
    end
    n_checks++;
    if (quotient !== eq) begin
      n_errors++;
      $display("FAIL quotient %0d/%0d got %0d exp %0d", a, b, quotient, eq);
    end
    n_checks++;
    if (remainder !== er) begin
      n_errors++;
      $display("FAIL remainder %0d/%0d got %0d exp %0d", a, b, remainder, er);
    end
    n_checks++;
    if (div_by_zero !== edz) begin
      n_errors++;
      $display("FAIL dbz %0d/%0d got %0b exp %0b", a, b, div_by_zero, edz);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL busy_at_done %0d/%0d got %0b exp 0", a, b, busy);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL pulse_end %0d/%0d done %0b busy %0b exp 0 0",
               a, b, done, busy);
    end
    n_checks++;
    if (quotient !== eq || remainder !== er || div_by_zero !== edz) begin
      n_errors++;
      $display("FAIL hold %0d/%0d got %0d r %0d exp %0d r %0d",
               a, b, quotient, remainder, eq, er);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; dividend = 16'd0; divisor = 16'd0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({quotient, remainder, busy, done, div_by_zero} !== 35'd0) begin
      n_errors++;
      $display("FAIL reset_state got q %0d r %0d b %0b d %0b z %0b exp 0",
               quotient, remainder, busy, done, div_by_zero);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    run_op(16'd100, 16'd7);
    run_op(16'hFFFF, 16'd1);
    run_op(16'hFFFF, 16'hFFFF);
    run_op(16'd3, 16'd10);
    run_op(16'd0, 16'd5);
  endtask

  task automatic test_div_zero();
    run_op(16'd5, 16'd0);
    run_op(16'd9, 16'd3);
    run_op(16'd0, 16'd0);
  endtask

  task automatic test_ignore_start();
    int ndone;
    int lat;
    @(negedge clk);
    start = 1'b1; dividend = 16'd1000; divisor = 16'd9;
    @(negedge clk);
    ndone = 0;
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      start = (k == 4) || (done === 1'b1);
      dividend = 16'd50;
      divisor = 16'd5;
      if (done === 1'b1) begin
        ndone++;
        if (lat < 0) lat = k;
      end
      @(negedge clk);
    end
    start = 1'b0;
    n_checks++;
    if (ndone !== 1 || lat !== 16) begin
      n_errors++;
      $display("FAIL ignore_done count %0d lat %0d exp 1 lat 16", ndone, lat);
    end
    n_checks++;
    if (quotient !== 16'd111 || remainder !== 16'd1) begin
      n_errors++;
      $display("FAIL ignore_result got %0d r %0d exp 111 r 1",
               quotient, remainder);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL ignore_busy got %0b exp 0", busy);
    end
  endtask

  task automatic test_reset_abort();
    int ndone;
    @(negedge clk);
    start = 1'b1; dividend = 16'd1000; divisor = 16'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({quotient, remainder, busy, done, div_by_zero} !== 35'd0) begin
      n_errors++;
      $display("FAIL abort_clear got q %0d r %0d b %0b d %0b z %0b exp 0",
               quotient, remainder, busy, done, div_by_zero);
    end
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      if (done === 1'b1 || busy === 1'b1) ndone++;
      @(negedge clk);
    end
    n_checks++;
    if (ndone !== 0) begin
      n_errors++;
      $display("FAIL abort_quiet active cycles %0d exp 0", ndone);
    end
    run_op(16'd1000, 16'd9);
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0: pick = 16'h0000;
      1: pick = 16'h0001;
      2: pick = 16'hFFFF;
      default: pick = 16'($urandom);
    endcase
  endfunction

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      run_op(pick(), pick());
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_basic();
    test_div_zero();
    test_ignore_start();
    test_reset_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
